// File: rtl/pll_mon_pkg.sv
// Shared types and constants for the PLL lock monitor.
package pll_mon_pkg;

  localparam int unsigned RELOCK_CNT_W = 8;

  typedef enum logic [1:0] {
    WAIT     = 2'd0,
    SETTLE   = 2'd1,
    LOCKED   = 2'd2,
    DEGLITCH = 2'd3
  } pll_mon_state_e;

  function automatic int unsigned pll_mon_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer for asynchronous status inputs; both stages reset to 0.
module pll_lock_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/pll_lock_monitor.sv
// Qualifies the raw PLL lock on the reference clock and keeps sticky loss/timeout status.
//
// state    | meaning
// WAIT     | no lock seen, waiting for synchronized lock high
// SETTLE   | lock high, counting consecutive high samples
// LOCKED   | qualified lock, lock_o asserted
// DEGLITCH | lock dropped while locked, counting consecutive low samples
module pll_lock_monitor
  import pll_mon_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES    = 1024,
  parameter int unsigned UNLOCK_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    pll_lock_raw_i,
  input  logic                    pll_bps_i,
  input  logic                    testmode_i,
  input  logic                    clear_i,
  output logic                    lock_o,
  output logic                    lock_lost_o,
  output logic                    timeout_o,
  output logic [RELOCK_CNT_W-1:0] relock_cnt_o
);

  localparam int unsigned QUAL_W = $clog2(pll_mon_max(LOCK_CYCLES, UNLOCK_CYCLES) + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [QUAL_W-1:0]       QUAL_ONE    = QUAL_W'(1);
  localparam logic [QUAL_W-1:0]       LOCK_LAST   = QUAL_W'(LOCK_CYCLES - 1);
  localparam logic [QUAL_W-1:0]       UNLOCK_LAST = QUAL_W'(UNLOCK_CYCLES - 1);
  localparam logic [TMO_W-1:0]        TMO_ONE     = TMO_W'(1);
  localparam logic [TMO_W-1:0]        TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0]        TMO_SAT     = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [RELOCK_CNT_W-1:0] RELOCK_ONE  = RELOCK_CNT_W'(1);
  localparam logic [RELOCK_CNT_W-1:0] RELOCK_MAX  = '1;

  logic                    lock_sync;
  pll_mon_state_e          state_q, state_d;
  logic [QUAL_W-1:0]       qual_cnt_q, qual_cnt_d;
  logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
  logic                    lock_q, lock_d;
  logic                    lock_lost_q, lock_lost_d;
  logic                    timeout_q, timeout_d;
  logic [RELOCK_CNT_W-1:0] relock_cnt_q, relock_cnt_d;
  logic                    loss_evt;
  logic                    tmo_evt;
  logic                    acquiring;

  pll_lock_sync #(
    .WIDTH(1)
  ) u_lock_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .async_i(pll_lock_raw_i),
    .sync_o (lock_sync)
  );

  always_comb begin
    state_d    = state_q;
    qual_cnt_d = qual_cnt_q;
    loss_evt   = 1'b0;
    case (state_q)
      WAIT: begin
        if (lock_sync) begin
          state_d    = SETTLE;
          qual_cnt_d = QUAL_ONE;
        end
      end
      SETTLE: begin
        if (!lock_sync) begin
          state_d    = WAIT;
          qual_cnt_d = '0;
        end else if (qual_cnt_q == LOCK_LAST) begin
          state_d = LOCKED;
        end else begin
          qual_cnt_d = qual_cnt_q + QUAL_ONE;
        end
      end
      LOCKED: begin
        if (!lock_sync) begin
          if (UNLOCK_CYCLES == 1) begin
            loss_evt = 1'b1;
          end else begin
            state_d    = DEGLITCH;
            qual_cnt_d = QUAL_ONE;
          end
        end
      end
      DEGLITCH: begin
        if (lock_sync) begin
          state_d = LOCKED;
        end else if (qual_cnt_q == UNLOCK_LAST) begin
          loss_evt = 1'b1;
        end else begin
          qual_cnt_d = qual_cnt_q + QUAL_ONE;
        end
      end
      default: state_d = WAIT;
    endcase
    if (loss_evt) begin
      state_d    = WAIT;
      qual_cnt_d = '0;
    end
  end

  // Acquisition timer only runs while hunting for lock; it restarts from zero after each loss.
  always_comb begin
    acquiring = (state_q == WAIT) || (state_q == SETTLE);
    tmo_cnt_d = tmo_cnt_q;
    tmo_evt   = 1'b0;
    if (acquiring) begin
      tmo_evt = (tmo_cnt_q == TMO_LAST);
      if (state_d == LOCKED) begin
        tmo_cnt_d = '0;
      end else if (tmo_cnt_q != TMO_SAT) begin
        tmo_cnt_d = tmo_cnt_q + TMO_ONE;
      end
    end else if (state_d == LOCKED) begin
      tmo_cnt_d = '0;
    end
  end

  // A set event on the same edge as clear_i wins over the clear.
  always_comb begin
    lock_d      = (state_d == LOCKED) || (state_d == DEGLITCH) || pll_bps_i || testmode_i;
    lock_lost_d = (lock_lost_q && !clear_i) || loss_evt;
    timeout_d   = (timeout_q && !clear_i) || tmo_evt;
    relock_cnt_d = relock_cnt_q;
    if (clear_i) begin
      relock_cnt_d = loss_evt ? RELOCK_ONE : '0;
    end else if (loss_evt && (relock_cnt_q != RELOCK_MAX)) begin
      relock_cnt_d = relock_cnt_q + RELOCK_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= WAIT;
      qual_cnt_q   <= '0;
      tmo_cnt_q    <= '0;
      lock_q       <= 1'b0;
      lock_lost_q  <= 1'b0;
      timeout_q    <= 1'b0;
      relock_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      qual_cnt_q   <= qual_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      lock_q       <= lock_d;
      lock_lost_q  <= lock_lost_d;
      timeout_q    <= timeout_d;
      relock_cnt_q <= relock_cnt_d;
    end
  end

  assign lock_o       = lock_q;
  assign lock_lost_o  = lock_lost_q;
  assign timeout_o    = timeout_q;
  assign relock_cnt_o = relock_cnt_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Scoreboard bench for pll_lock_monitor with LOCK=16, UNLOCK=4, TIMEOUT=64.
module tb_pll_lock_monitor;

  logic       clk = 1'b0;
  logic       rstn;
  logic       raw;
  logic       bps;
  logic       tm;
  logic       clr;
  logic       lock;
  logic       lost;
  logic       tmo;
  logic [7:0] cnt;

  typedef struct {
    int         when;
    string      name;
    logic       lock;
    logic       lost;
    logic       tmo;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  pll_lock_monitor #(
    .LOCK_CYCLES   (16),
    .UNLOCK_CYCLES (4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .pll_lock_raw_i(raw),
    .pll_bps_i     (bps),
    .testmode_i    (tm),
    .clear_i       (clr),
    .lock_o        (lock),
    .lock_lost_o   (lost),
    .timeout_o     (tmo),
    .relock_cnt_o  (cnt)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: compares every expectation due at or before the current edge count.
  initial forever begin
    exp_t e;
    @(negedge clk);
    while (sb.size() > 0 && sb[0].when <= cyc) begin
      e = sb.pop_front();
      n_checks++;
      if (lock !== e.lock || lost !== e.lost || tmo !== e.tmo || cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL %s @edge %0d: lock/lost/tmo/cnt got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                 e.name, cyc, lock, lost, tmo, cnt, e.lock, e.lost, e.tmo, e.cnt);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input int when, input string nm, input logic lk, input logic ll,
                          input logic to, input int c);
    exp_t e;
    e.when = when;
    e.name = nm;
    e.lock = lk;
    e.lost = ll;
    e.tmo  = to;
    e.cnt  = 8'(c);
    sb.push_back(e);
  endtask

  initial begin
    int c;
    int d;
    int cnt_e;
    int nxt;
    int guard;
    exp_t e;

    rstn = 1'b0;
    raw  = 1'b0;
    bps  = 1'b0;
    tm   = 1'b0;
    clr  = 1'b0;

    // Reset values, then timeout with raw held low
    tick(2);
    push_exp(cyc + 1, "reset", 0, 0, 0, 0);
    tick(2);
    rstn = 1'b1;
    c = cyc;
    push_exp(c + 63, "tmo_pre", 0, 0, 0, 0);
    push_exp(c + 64, "tmo_set", 0, 0, 1, 0);
    tick(64);

    // Acquisition continues after timeout; timeout stays set
    c = cyc;
    raw = 1'b1;
    push_exp(c + 17, "acq_pre", 0, 0, 1, 0);
    push_exp(c + 18, "acq_lock", 1, 0, 1, 0);
    tick(18);

    c = cyc;
    push_exp(c + 1, "clear_tmo", 1, 0, 0, 0);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;

    // 3-cycle drop is filtered
    c = cyc;
    raw = 1'b0;
    for (int i = 3; i <= 8; i++) push_exp(c + i, "glitch3", 1, 0, 0, 0);
    tick(3);
    raw = 1'b1;
    tick(6);

    // 4-cycle drop is a qualified loss, then relock
    c = cyc;
    raw = 1'b0;
    push_exp(c + 5, "loss_pre", 1, 0, 0, 0);
    push_exp(c + 6, "loss4", 0, 1, 0, 1);
    push_exp(c + 21, "relock_pre", 0, 1, 0, 1);
    push_exp(c + 22, "relock", 1, 1, 0, 1);
    tick(4);
    raw = 1'b1;
    tick(18);

    // clear_i on the loss edge: set wins, count restarts at 1
    c = cyc;
    raw = 1'b0;
    push_exp(c + 6, "clr_collide", 0, 1, 0, 1);
    tick(5);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(4);

    // 300 further losses saturate the count
    cnt_e = 1;
    for (int i = 0; i < 300; i++) begin
      c = cyc;
      raw = 1'b1;
      nxt = (cnt_e < 255) ? cnt_e + 1 : 255;
      push_exp(c + 18, "loop_lock", 1, 1, 0, cnt_e);
      push_exp(c + 24, "loop_loss", 0, 1, 0, nxt);
      tick(18);
      raw = 1'b0;
      tick(6);
      cnt_e = nxt;
    end

    n_checks++;
    if (cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_cnt @edge %0d: relock_cnt got %0d expected 255", cyc, cnt);
    end
    n_checks++;
    if (lock !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_lock @edge %0d: lock got %b expected 0", cyc, lock);
    end
    n_checks++;
    if (lost !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_lost @edge %0d: lock_lost got %b expected 1", cyc, lost);
    end

    // Bypass with raw low, then async reset mid-SETTLE
    c = cyc;
    bps = 1'b1;
    push_exp(c + 1, "bypass", 1, 1, 0, 255);
    push_exp(c + 5, "bps_settle", 1, 1, 0, 255);
    tick(1);
    raw = 1'b1;
    tick(4);
    push_exp(cyc + 1, "async_rst", 0, 0, 0, 0);
    @(posedge clk);
    #1 rstn = 1'b0;
    tick(1);
    push_exp(cyc + 1, "rst_hold", 0, 0, 0, 0);
    tick(1);
    d = cyc;
    rstn = 1'b1;
    push_exp(d + 1, "bps_after_rst", 1, 0, 0, 0);
    push_exp(d + 2, "bps_drop", 0, 0, 0, 0);
    push_exp(d + 17, "restart_pre", 0, 0, 0, 0);
    push_exp(d + 18, "restart_lock", 1, 0, 0, 0);
    tick(1);
    bps = 1'b0;
    tick(17);

    // Testmode holds lock_o while status still records the loss
    c = cyc;
    tm = 1'b1;
    raw = 1'b0;
    push_exp(c + 1, "tm_hold", 1, 0, 0, 0);
    push_exp(c + 6, "tm_loss", 1, 1, 0, 1);
    push_exp(c + 7, "tm_drop", 0, 1, 0, 1);
    tick(6);
    tm = 1'b0;
    tick(1);

    // Fresh reset, unstable lock: 10 high, 1 low, then high
    rstn = 1'b0;
    push_exp(cyc + 1, "rst2", 0, 0, 0, 0);
    tick(3);
    rstn = 1'b1;
    tick(2);
    c = cyc;
    raw = 1'b1;
    push_exp(c + 12, "unstable_mid", 0, 0, 0, 0);
    push_exp(c + 28, "unstable_pre", 0, 0, 0, 0);
    push_exp(c + 29, "unstable_lock", 1, 0, 0, 0);
    tick(10);
    raw = 1'b0;
    tick(1);
    raw = 1'b1;
    tick(18);

    guard = 0;
    while (sb.size() > 0 && guard < 100) begin
      tick(1);
      guard++;
    end

    n_checks++;
    if (lock !== 1'b1) begin
      n_fail++;
      $display("FAIL final_lock @edge %0d: lock got %b expected 1", cyc, lock);
    end
    n_checks++;
    if (lost !== 1'b0) begin
      n_fail++;
      $display("FAIL final_lost @edge %0d: lock_lost got %b expected 0", cyc, lost);
    end
    n_checks++;
    if (tmo !== 1'b0) begin
      n_fail++;
      $display("FAIL final_tmo @edge %0d: timeout got %b expected 0", cyc, tmo);
    end
    n_checks++;
    if (cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL final_cnt @edge %0d: relock_cnt got %0d expected 0", cyc, cnt);
    end

    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: expectation for edge %0d never checked (now %0d)", e.name, e.when, cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
